// File: rtl/ref_scoreboard.sv
// ref_scoreboard: refresh sweep controller with per-row coverage scoreboard, on-demand
// refreshes for reads of stale rows, and a retention timer. Optional macro: REF_SKIP_EN.
`default_nettype none

module ref_scoreboard #(
    parameter int ROWS       = 128,
    parameter int AW         = $clog2(ROWS),
    parameter int RET_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic          o_ref_valid,
    output logic [AW-1:0] o_ref_addr,
    input  logic          i_ref_ready,
    output logic          o_ref_demand,
    output logic          o_rd_hit,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_overrun
);

    localparam int TW = (RET_CYCLES > 1) ? $clog2(RET_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [ROWS-1:0] r_sb, w_sb_nxt;
    logic [AW-1:0]   r_ptr, w_ptr_nxt;
    logic [TW-1:0]   r_timer;
    logic            r_overrun;

    logic w_expire, w_in_sweep, w_demand, w_sweep_req, w_skip, w_xfer, w_ptr_adv, w_ptr_last;

    assign w_expire   = (r_timer == TW'(RET_CYCLES - 1));
    assign w_ptr_last = (r_ptr == AW'(ROWS - 1));
    assign w_in_sweep = (r_state == S_SWEEP);
    assign w_demand   = w_in_sweep && i_rd_en && !r_sb[i_rd_addr];

`ifdef REF_SKIP_EN
    // Already-covered rows are stepped over without a transfer.
    assign w_sweep_req = w_in_sweep && !r_sb[r_ptr];
    assign w_skip      = w_in_sweep && !w_demand && r_sb[r_ptr];
`else
    assign w_sweep_req = w_in_sweep;
    assign w_skip      = 1'b0;
`endif

    assign o_ref_valid  = w_demand || w_sweep_req;
    assign o_ref_addr   = w_demand ? i_rd_addr : r_ptr;
    assign o_ref_demand = w_demand;
    assign w_xfer       = o_ref_valid && i_ref_ready;
    // Demand transfers never move the sweep pointer.
    assign w_ptr_adv    = (w_xfer && !w_demand) || w_skip;

    assign o_rd_hit  = (r_state == S_IDLE) ? 1'b1 : r_sb[i_rd_addr];
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = (r_state == S_DONE);
    assign o_overrun = r_overrun;

    always_comb begin
        w_state_nxt = r_state;
        w_sb_nxt    = r_sb;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (i_start || w_expire) begin
                    w_state_nxt = S_SWEEP;
                    w_sb_nxt    = '0;
                    w_ptr_nxt   = '0;
                end
            end
            S_SWEEP: begin
                if (w_xfer) begin
                    w_sb_nxt[o_ref_addr] = 1'b1;
                end
                if (i_wr_en) begin
                    w_sb_nxt[i_wr_addr] = 1'b1;
                end
                if (w_ptr_adv) begin
                    w_ptr_nxt = r_ptr + 1'b1;
                    if (w_ptr_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_sb_nxt    = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_sb_nxt    = '0;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sb      <= '0;
            r_ptr     <= '0;
            r_timer   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sb    <= w_sb_nxt;
            r_ptr   <= w_ptr_nxt;
            if ((r_state == S_IDLE && i_start) || w_expire) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_expire && r_state != S_IDLE) begin
                r_overrun <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ref_scoreboard.sv
// tb_ref_scoreboard: directed checks of ref_scoreboard with ROWS=8, RET_CYCLES=64.
`default_nettype none

module tb_ref_scoreboard;

    localparam int ROWS = 8;
    localparam int AW   = 3;
    localparam int RET  = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          ref_ready = 1'b0;
    logic          ref_valid, ref_demand, rd_hit, busy, done, overrun;
    logic [AW-1:0] ref_addr;

    int checks = 0;
    int errors = 0;

    ref_scoreboard #(.ROWS(ROWS), .AW(AW), .RET_CYCLES(RET)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_rd_en     (rd_en),
        .i_rd_addr   (rd_addr),
        .o_ref_valid (ref_valid),
        .o_ref_addr  (ref_addr),
        .i_ref_ready (ref_ready),
        .o_ref_demand(ref_demand),
        .o_rd_hit    (rd_hit),
        .o_busy      (busy),
        .o_done      (done),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; start = 1'b0; wr_en = 1'b0; rd_en = 1'b0; ref_ready = 1'b0;
        wr_addr = '0; rd_addr = '0;
        tick;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int n, xfers;
        logic seen34, reached;

        // Reset state
        #2;
        chk("rst_valid", 32'(ref_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_rd_hit", 32'(rd_hit), 1);
        chk("rst_ref_addr", 32'(ref_addr), 0);
        chk("rst_demand", 32'(ref_demand), 0);

        // Plain pass: rows 0..7 on consecutive cycles, then done
        do_reset;
        ref_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        #1;
        for (int i = 0; i < ROWS; i++) begin
            chk("pass_valid", 32'(ref_valid), 1);
            chk("pass_addr", 32'(ref_addr), 32'(i));
            chk("pass_busy", 32'(busy), 1);
            tick;
        end
        chk("pass_done", 32'(done), 1);
        chk("pass_done_valid", 32'(ref_valid), 0);
        tick;
        chk("pass_idle_busy", 32'(busy), 0);
        chk("pass_idle_done", 32'(done), 0);

        // Stall at ptr=1
        do_reset;
        ref_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        ref_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(ref_valid), 1);
            chk("stall_addr", 32'(ref_addr), 1);
            tick;
        end
        chk("stall_hold_addr", 32'(ref_addr), 1);
        ref_ready = 1'b1;
        tick;
        chk("stall_release_addr", 32'(ref_addr), 2);

        // Demand read of row 6 at ptr=2
        rd_en = 1'b1;
        rd_addr = 3'd6;
        #1;
        chk("dem_hit_before", 32'(rd_hit), 0);
        chk("dem_valid", 32'(ref_valid), 1);
        chk("dem_addr", 32'(ref_addr), 6);
        chk("dem_flag", 32'(ref_demand), 1);
        tick;
        rd_en = 1'b0;
        #1;
        chk("dem_ptr_kept", 32'(ref_addr), 2);
        chk("dem_flag_off", 32'(ref_demand), 0);
        chk("dem_hit_after", 32'(rd_hit), 1);
        rd_addr = 3'd7;
        #1;
        chk("dem_hit_row7", 32'(rd_hit), 0);
        for (int i = 0; i < 6; i++) tick;
        chk("dem_done", 32'(done), 1);
        tick;
        chk("dem_idle", 32'(busy), 0);

        // Writes to rows 3,4 ahead of the sweep
        do_reset;
        ref_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        wr_en = 1'b1;
        wr_addr = 3'd3;
        tick;
        wr_addr = 3'd4;
        tick;
        wr_en = 1'b0;
        xfers = 0;
        seen34 = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (done) begin
                reached = 1'b1;
                break;
            end
            if (ref_valid && ref_ready) begin
                xfers++;
                if (ref_addr == 3'd3 || ref_addr == 3'd4) seen34 = 1'b1;
            end
            tick;
        end
        chk("wr_reached_done", 32'(reached), 1);
`ifdef REF_SKIP_EN
        chk("wr_xfers", 32'(xfers), 4);
        chk("wr_seen34", 32'(seen34), 0);
`else
        chk("wr_xfers", 32'(xfers), 6);
        chk("wr_seen34", 32'(seen34), 1);
`endif

        // Reset mid-pass at ptr=5
        do_reset;
        ref_ready = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        chk("mid_ptr5", 32'(ref_addr), 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(ref_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_addr", 32'(ref_addr), 0);
        tick;
        rst = 1'b0;
        rd_addr = 3'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        #1;
        chk("mid_restart_addr", 32'(ref_addr), 0);
        chk("mid_restart_hit", 32'(rd_hit), 0);

        // Auto-start from timer, then overrun while stalled
        do_reset;
        n = 0;
        while (!busy && n < 100) begin
            tick;
            n++;
        end
        chk("auto_start_cycle", 32'(n), 64);
        for (int i = 0; i < 63; i++) tick;
        chk("ovr_before", 32'(overrun), 0);
        tick;
        chk("ovr_set", 32'(overrun), 1);
        for (int i = 0; i < 10; i++) tick;
        chk("ovr_sticky", 32'(overrun), 1);
        chk("ovr_still_busy", 32'(busy), 1);
        chk("ovr_addr_held", 32'(ref_addr), 0);
        rst = 1'b1;
        #1;
        chk("ovr_cleared", 32'(overrun), 0);
        tick;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
